issue_queue: RTL and testbench

Per-functional-unit issue queue sitting directly downstream of the rename stage. It accepts renamed instructions steered to its FU (`fu_choice == FU_ID`) and holds them until all source PRNs are ready. It tracks readiness through wakeup broadcasts and issues the oldest fully-ready entry into a registered issue slot with a valid/ready handshake toward the FU. It provides backpressure (`full`) upstream and supports a full flush for rollback.

---
 rtl/issue_queue.sv | 256 +++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue: per-FU collapsing issue queue behind rename.
// Accepts renamed instructions steered to FU_ID, tracks per-source
// readiness through wakeup broadcasts, and issues the oldest fully-ready
// entry into a registered issue slot (valid/ready toward the FU).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mapping_valid, inst_id, raw_instr, instr_pc, fu_choice,
//   prn_input_valid/ready/prn_input, prn_output_valid/prn_output
//                            : renamed instruction from the rename stage
//   wake_valid, wake_prn     : PRN-ready broadcasts
//   flush                    : discard queue and issue slot
//   fu_ready                 : FU consumes the issue slot this cycle
//   full, overflow           : backpressure and sticky drop indicator
//   issue_*                  : registered issue slot payload
module issue_queue #(
  parameter int ENTRIES      = 8,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int FUC_BITS     = $clog2(FU_COUNT),
  parameter int FU_ID        = 0,
  parameter int WAKE_PORTS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mapping_valid,
  input  logic [INST_ID_BITS-1:0] inst_id,
  input  logic [31:0]             raw_instr,
  input  logic [63:0]             instr_pc,
  input  logic [FUC_BITS-1:0]     fu_choice,
  input  logic                    prn_input_valid [MAX_OPERANDS],
  input  logic                    prn_input_ready [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     prn_input [MAX_OPERANDS],
  input  logic                    prn_output_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     prn_output [MAX_OPERANDS],
  input  logic                    wake_valid [WAKE_PORTS],
  input  logic [PRN_BITS-1:0]     wake_prn [WAKE_PORTS],
  input  logic                    flush,
  input  logic                    fu_ready,
  output logic                    full,
  output logic                    overflow,
  output logic                    issue_valid,
  output logic [INST_ID_BITS-1:0] issue_inst_id,
  output logic [31:0]             issue_raw_instr,
  output logic [63:0]             issue_pc,
  output logic [PRN_BITS-1:0]     issue_prn_input [MAX_OPERANDS],
  output logic                    issue_prn_input_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     issue_prn_output [MAX_OPERANDS],
  output logic                    issue_prn_output_valid [MAX_OPERANDS]
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  // Entry storage; index 0 is always the oldest occupied entry.
  logic [INST_ID_BITS-1:0] e_id_r  [ENTRIES];
  logic [31:0]             e_raw_r [ENTRIES];
  logic [63:0]             e_pc_r  [ENTRIES];
  logic [PRN_BITS-1:0]     e_src_r [ENTRIES][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     e_dst_r [ENTRIES][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] e_src_v_r [ENTRIES];
  logic [MAX_OPERANDS-1:0] e_dst_v_r [ENTRIES];
  logic [MAX_OPERANDS-1:0] e_rdy_r   [ENTRIES];

  logic [INST_ID_BITS-1:0] nxt_id_s  [ENTRIES];
  logic [31:0]             nxt_raw_s [ENTRIES];
  logic [63:0]             nxt_pc_s  [ENTRIES];
  logic [PRN_BITS-1:0]     nxt_src_s [ENTRIES][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     nxt_dst_s [ENTRIES][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] nxt_src_v_s [ENTRIES];
  logic [MAX_OPERANDS-1:0] nxt_dst_v_s [ENTRIES];
  logic [MAX_OPERANDS-1:0] nxt_rdy_s   [ENTRIES];
  logic [IDX_W-1:0]        src_idx_s   [ENTRIES];

  logic [CNT_W-1:0] count_r, count_nxt_s, enq_pos_s;
  logic             full_r, overflow_r;
  logic             steer_s, enq_s, issue_s, any_elig_s;
  logic [IDX_W-1:0] sel_s;
  logic [MAX_OPERANDS-1:0] in_src_v_s, in_dst_v_s, in_rdy_s;

  // Issue slot registers.
  logic                    iss_valid_r;
  logic [INST_ID_BITS-1:0] iss_id_r;
  logic [31:0]             iss_raw_r;
  logic [63:0]             iss_pc_r;
  logic [PRN_BITS-1:0]     iss_src_r [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     iss_dst_r [MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] iss_src_v_r, iss_dst_v_r;

  // True when any active wake port broadcasts this PRN.
  function automatic logic wake_hit(input logic [PRN_BITS-1:0] prn);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (wake_valid[k] && (wake_prn[k] == prn)) hit = 1'b1;
      else hit = hit;
    end
    return hit;
  endfunction

  assign steer_s     = mapping_valid && (fu_choice == FUC_BITS'(FU_ID));
  assign enq_s       = steer_s && !full_r && !flush;
  assign issue_s     = any_elig_s && (!iss_valid_r || fu_ready) && !flush;
  // A same-cycle issue collapses the queue, so the new entry lands one lower.
  assign enq_pos_s   = count_r - CNT_W'(issue_s);
  assign count_nxt_s = count_r + CNT_W'(enq_s) - CNT_W'(issue_s);

  // Pack incoming operand flags; a same-cycle wakeup bypasses into rdy.
  always_comb begin
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      in_src_v_s[j] = prn_input_valid[j];
      in_dst_v_s[j] = prn_output_valid[j];
      in_rdy_s[j]   = !prn_input_valid[j] || prn_input_ready[j] || wake_hit(prn_input[j]);
    end
  end

  // Oldest-first select: lowest occupied index with every source ready.
  always_comb begin
    sel_s      = '0;
    any_elig_s = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!any_elig_s && (CNT_W'(i) < count_r) && (&e_rdy_r[i])) begin
        sel_s      = IDX_W'(i);
        any_elig_s = 1'b1;
      end else begin
        any_elig_s = any_elig_s;
      end
    end
  end

  // Collapse source: entries at or above the issued one pull from the slot above.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue_s && (IDX_W'(i) >= sel_s) && (i < ENTRIES - 1)) src_idx_s[i] = IDX_W'(i + 1);
      else src_idx_s[i] = IDX_W'(i);
    end
  end

  // Next entry contents: collapsed resident entries with wakeups applied, or the new enqueue.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (enq_s && (CNT_W'(i) == enq_pos_s)) begin
        nxt_id_s[i]    = inst_id;
        nxt_raw_s[i]   = raw_instr;
        nxt_pc_s[i]    = instr_pc;
        nxt_src_v_s[i] = in_src_v_s;
        nxt_dst_v_s[i] = in_dst_v_s;
        nxt_rdy_s[i]   = in_rdy_s;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          nxt_src_s[i][j] = prn_input[j];
          nxt_dst_s[i][j] = prn_output[j];
        end
      end else begin
        nxt_id_s[i]    = e_id_r[src_idx_s[i]];
        nxt_raw_s[i]   = e_raw_r[src_idx_s[i]];
        nxt_pc_s[i]    = e_pc_r[src_idx_s[i]];
        nxt_src_v_s[i] = e_src_v_r[src_idx_s[i]];
        nxt_dst_v_s[i] = e_dst_v_r[src_idx_s[i]];
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          nxt_src_s[i][j] = e_src_r[src_idx_s[i]][j];
          nxt_dst_s[i][j] = e_dst_r[src_idx_s[i]][j];
          nxt_rdy_s[i][j] = e_rdy_r[src_idx_s[i]][j]
                          | (e_src_v_r[src_idx_s[i]][j] & wake_hit(e_src_r[src_idx_s[i]][j]));
        end
      end
    end
  end

  // Entry storage update; flush needs no clearing because count drops to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        e_id_r[i]    <= '0;
        e_raw_r[i]   <= '0;
        e_pc_r[i]    <= '0;
        e_src_v_r[i] <= '0;
        e_dst_v_r[i] <= '0;
        e_rdy_r[i]   <= '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          e_src_r[i][j] <= '0;
          e_dst_r[i][j] <= '0;
        end
      end
    end else begin
      e_id_r    <= nxt_id_s;
      e_raw_r   <= nxt_raw_s;
      e_pc_r    <= nxt_pc_s;
      e_src_v_r <= nxt_src_v_s;
      e_dst_v_r <= nxt_dst_v_s;
      e_rdy_r   <= nxt_rdy_s;
      e_src_r   <= nxt_src_s;
      e_dst_r   <= nxt_dst_s;
    end
  end

  // Occupancy, registered full flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= '0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (flush) begin
      count_r <= '0;
      full_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(ENTRIES));
      if (steer_s && full_r) overflow_r <= 1'b1;
    end
  end

  // Issue slot: load on issue, drop when consumed with nothing to replace it, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_r <= 1'b0;
      iss_id_r    <= '0;
      iss_raw_r   <= '0;
      iss_pc_r    <= '0;
      iss_src_v_r <= '0;
      iss_dst_v_r <= '0;
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        iss_src_r[j] <= '0;
        iss_dst_r[j] <= '0;
      end
    end else if (flush) begin
      iss_valid_r <= 1'b0;
    end else if (issue_s) begin
      iss_valid_r <= 1'b1;
      iss_id_r    <= e_id_r[sel_s];
      iss_raw_r   <= e_raw_r[sel_s];
      iss_pc_r    <= e_pc_r[sel_s];
      iss_src_v_r <= e_src_v_r[sel_s];
      iss_dst_v_r <= e_dst_v_r[sel_s];
      iss_src_r   <= e_src_r[sel_s];
      iss_dst_r   <= e_dst_r[sel_s];
    end else if (fu_ready) begin
      iss_valid_r <= 1'b0;
    end
  end

  assign full            = full_r;
  assign overflow        = overflow_r;
  assign issue_valid     = iss_valid_r;
  assign issue_inst_id   = iss_id_r;
  assign issue_raw_instr = iss_raw_r;
  assign issue_pc        = iss_pc_r;

  for (genvar g = 0; g < MAX_OPERANDS; g++) begin : g_issue_ops
    assign issue_prn_input[g]        = iss_src_r[g];
    assign issue_prn_input_valid[g]  = iss_src_v_r[g];
    assign issue_prn_output[g]       = iss_dst_r[g];
    assign issue_prn_output_valid[g] = iss_dst_v_r[g];
  end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mapping_valid;
  logic [5:0]  inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic [1:0]  fu_choice;
  logic        prn_input_valid [3];
  logic        prn_input_ready [3];
  logic [5:0]  prn_input [3];
  logic        prn_output_valid [3];
  logic [5:0]  prn_output [3];
  logic        wake_valid [3];
  logic [5:0]  wake_prn [3];
  logic        flush;
  logic        fu_ready;
  logic        full;
  logic        overflow;
  logic        issue_valid;
  logic [5:0]  issue_inst_id;
  logic [31:0] issue_raw_instr;
  logic [63:0] issue_pc;
  logic [5:0]  issue_prn_input [3];
  logic        issue_prn_input_valid [3];
  logic [5:0]  issue_prn_output [3];
  logic        issue_prn_output_valid [3];

  issue_queue dut (
    .clk(clk), .rst(rst), .mapping_valid(mapping_valid), .inst_id(inst_id),
    .raw_instr(raw_instr), .instr_pc(instr_pc), .fu_choice(fu_choice),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
    .prn_input(prn_input), .prn_output_valid(prn_output_valid), .prn_output(prn_output),
    .wake_valid(wake_valid), .wake_prn(wake_prn), .flush(flush), .fu_ready(fu_ready),
    .full(full), .overflow(overflow), .issue_valid(issue_valid),
    .issue_inst_id(issue_inst_id), .issue_raw_instr(issue_raw_instr), .issue_pc(issue_pc),
    .issue_prn_input(issue_prn_input), .issue_prn_input_valid(issue_prn_input_valid),
    .issue_prn_output(issue_prn_output), .issue_prn_output_valid(issue_prn_output_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] id;
    int         cyc;   // negedge cycle at which the issue must first appear; -1 = any
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int fails  = 0;

  function automatic logic [31:0] raw_of(input logic [5:0] id);
    return {8'hA5, 18'd0, id};
  endfunction

  function automatic logic [63:0] pc_of(input logic [5:0] id);
    return {32'hFFFF_0000, 26'd0, id};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_issue(input logic [5:0] id, input int at);
    exp_t e;
    e.id  = id;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Monitor: each newly presented issue slot pops one scoreboard entry.
  initial begin
    logic prev_v;
    logic prev_hs;
    exp_t e;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && issue_valid === 1'b1 && (!prev_v || prev_hs)) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_issue: got id %0d, expected no issue (cycle %0d)", issue_inst_id, cyc);
        end else begin
          e = sb_q.pop_front();
          check("issue_id", 64'(issue_inst_id), 64'(e.id));
          check("issue_raw", 64'(issue_raw_instr), 64'(raw_of(e.id)));
          check("issue_pc", issue_pc, pc_of(e.id));
          if (e.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_v  = (issue_valid === 1'b1);
      prev_hs = (issue_valid === 1'b1) && (fu_ready === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [5:0] id, input logic [2:0] srcv, input logic [2:0] srcr,
                      input logic [5:0] p0, input logic [1:0] fu);
    mapping_valid = 1'b1;
    inst_id       = id;
    raw_instr     = raw_of(id);
    instr_pc      = pc_of(id);
    fu_choice     = fu;
    for (int j = 0; j < 3; j++) begin
      prn_input_valid[j]  = srcv[j];
      prn_input_ready[j]  = srcr[j];
      prn_input[j]        = (j == 0) ? p0 : 6'(id + 6'(j));
      prn_output_valid[j] = (j == 0);
      prn_output[j]       = 6'(id + 6'd32);
    end
    tick();
    mapping_valid = 1'b0;
  endtask

  task automatic send_ready(input logic [5:0] id);
    send(id, 3'b111, 3'b111, 6'(id + 6'd40), 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; mapping_valid = 1'b0; inst_id = '0; raw_instr = '0; instr_pc = '0;
    fu_choice = '0; flush = 1'b0; fu_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      prn_input_valid[j] = 1'b0; prn_input_ready[j] = 1'b0; prn_input[j] = '0;
      prn_output_valid[j] = 1'b0; prn_output[j] = '0;
      wake_valid[j] = 1'b0; wake_prn[j] = '0;
    end
    idle(3);
    rst = 1'b0;

    // Reset state
    check("rst_full", 64'(full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_id", 64'(issue_inst_id), 64'd0);
    check("rst_issue_pc", issue_pc, 64'd0);
    check("rst_issue_raw", 64'(issue_raw_instr), 64'd0);

    // Minimum accept-to-issue latency
    c = cyc;
    expect_issue(6'd5, c + 2);
    send_ready(6'd5);
    idle(4);
    check("s1_full", 64'(full), 64'd0);

    // Instruction for another FU is ignored
    send(6'd20, 3'b111, 3'b111, 6'd1, 2'd2);
    idle(4);
    check("wrongfu_overflow", 64'(overflow), 64'd0);
    check("wrongfu_full", 64'(full), 64'd0);

    // Out-of-order issue around a waiting entry, then wakeup
    c = cyc;
    expect_issue(6'd2, c + 3);
    expect_issue(6'd3, c + 4);
    send(6'd1, 3'b001, 3'b000, 6'd9, 2'd0);
    send_ready(6'd2);
    send_ready(6'd3);
    idle(4);
    c = cyc;
    expect_issue(6'd1, c + 2);
    wake_valid[0] = 1'b1; wake_prn[0] = 6'd9;
    tick();
    wake_valid[0] = 1'b0;
    idle(4);

    // Same-cycle wakeup bypass on enqueue
    c = cyc;
    expect_issue(6'd7, c + 2);
    wake_valid[1] = 1'b1; wake_prn[1] = 6'd12;
    send(6'd7, 3'b001, 3'b000, 6'd12, 2'd0);
    wake_valid[1] = 1'b0;
    idle(4);

    // Fill with a stalled FU, overflow, stable hold, then drain
    fu_ready = 1'b0;
    c = cyc;
    expect_issue(6'd10, c + 2);
    for (int k = 1; k < 9; k++) expect_issue(6'(10 + k), -1);
    for (int k = 0; k < 9; k++) send_ready(6'(10 + k));
    check("fill_full", 64'(full), 64'd1);
    check("fill_overflow_pre", 64'(overflow), 64'd0);
    send_ready(6'd19);
    check("fill_overflow", 64'(overflow), 64'd1);
    check("fill_full_after", 64'(full), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 64'(issue_valid), 64'd1);
      check("stall_id", 64'(issue_inst_id), 64'd10);
      tick();
    end
    fu_ready = 1'b1;
    idle(12);
    check("drain_full", 64'(full), 64'd0);

    // Flush with a held slot and a simultaneous enqueue
    fu_ready = 1'b0;
    c = cyc;
    expect_issue(6'd30, c + 2);
    for (int k = 0; k < 5; k++) send_ready(6'(30 + k));
    check("preflush_valid", 64'(issue_valid), 64'd1);
    check("preflush_id", 64'(issue_inst_id), 64'd30);
    flush = 1'b1;
    send_ready(6'd35);
    flush = 1'b0;
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_full", 64'(full), 64'd0);
    check("flush_overflow_kept", 64'(overflow), 64'd1);
    fu_ready = 1'b1;
    idle(4);
    c = cyc;
    expect_issue(6'd36, c + 2);
    send_ready(6'd36);
    idle(4);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
